// File: rtl/shift_rows_serial_pkg.sv
// Shared AES definitions: block size, byte type and the ShiftRows source-index mapping.
package shift_rows_serial_pkg;

    localparam int BLOCK_BYTES = 16;

    typedef logic [7:0] byte_t;

    // Column-major index k = row + 4*col; the output byte at k is read from this source index.
    function automatic logic [3:0] src_idx(input logic [3:0] k, input bit inv);
        logic [1:0] row;
        logic [1:0] col;
        logic [1:0] scol;
        row  = k[1:0];
        col  = k[3:2];
        scol = inv ? (col - row) : (col + row);
        return {scol, row};
    endfunction

endpackage

// File: rtl/shift_rows_serial.sv
// Byte-serial AES ShiftRows / InvShiftRows with a ping-pong pair of 16-byte banks,
// so one block can be written while the previous one is read out permuted.
module shift_rows_serial
    import shift_rows_serial_pkg::*;
#(
    parameter bit INV = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] dIn,
    input  logic       inValid,
    output logic       inReady,
    output logic [7:0] dOut,
    output logic       outValid,
    input  logic       outReady,
    output logic       colFirst,
    output logic       outLast
);

    byte_t       r_bank [2][BLOCK_BYTES];
    logic        r_wrBank;
    logic        r_rdBank;
    logic [3:0]  r_wrCnt;
    logic [3:0]  r_rdCnt;
    logic [1:0]  r_full;

    logic        w_wrEn;
    logic        w_rdEn;
    logic        w_wrDone;
    logic        w_rdDone;
    logic [1:0]  w_fullNxt;
    logic [3:0]  w_srcIdx;

    assign inReady  = ~r_full[r_wrBank];
    assign outValid = r_full[r_rdBank];

    assign w_wrEn   = inValid & inReady;
    assign w_rdEn   = outValid & outReady;
    assign w_wrDone = w_wrEn & (r_wrCnt == 4'd15);
    assign w_rdDone = w_rdEn & (r_rdCnt == 4'd15);

    // A bank being filled is never the bank being drained, so both updates can land together.
    always_comb begin
        w_fullNxt = r_full;
        if (w_wrDone) w_fullNxt[r_wrBank] = 1'b1;
        if (w_rdDone) w_fullNxt[r_rdBank] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrBank <= 1'b0;
            r_rdBank <= 1'b0;
            r_wrCnt  <= 4'd0;
            r_rdCnt  <= 4'd0;
            r_full   <= 2'b00;
        end else begin
            r_full <= w_fullNxt;
            if (w_wrEn) begin
                r_wrCnt <= r_wrCnt + 4'd1;
                if (w_wrDone) r_wrBank <= ~r_wrBank;
            end
            if (w_rdEn) begin
                r_rdCnt <= r_rdCnt + 4'd1;
                if (w_rdDone) r_rdBank <= ~r_rdBank;
            end
        end
    end

    // Bank contents are plain storage; validity is tracked only by the full flags.
    always_ff @(posedge clk) begin
        if (w_wrEn) r_bank[r_wrBank][r_wrCnt] <= dIn;
    end

    assign w_srcIdx = src_idx(r_rdCnt, INV);
    assign dOut     = outValid ? r_bank[r_rdBank][w_srcIdx] : 8'h00;
    assign colFirst = outValid & (r_rdCnt[1:0] == 2'd0);
    assign outLast  = outValid & (r_rdCnt == 4'd15);

endmodule

// File: doc/shift_rows_serial.md
SHIFT_ROWS_SERIAL -- requirements
Module: shift_rows_serial

Interface
REQ-001 Parameter: INV, default 0, 0 = ShiftRows, 1 = InvShiftRows.
REQ-002 Port: clk  input  1  sole clock, all state updates on posedge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: dIn  input  8  input state byte, column-major order (index = row + 4*col).
REQ-005 Port: inValid  input  1  dIn holds a valid byte.
REQ-006 Port: inReady  output  1  block accepts dIn this cycle.
REQ-007 Port: dOut  output  8  shifted state byte, column-major order.
REQ-008 Port: outValid  output  1  dOut holds a valid byte.
REQ-009 Port: outReady  input  1  downstream (mixColumns) accepts dOut this cycle.
REQ-010 Port: colFirst  output  1  high when the current dOut byte is row 0 of a column; drives the downstream mixColumns en as ~colFirst.
REQ-011 Port: outLast  output  1  high when the current dOut byte is output index 15.

Function
REQ-012 Storage: two 16-byte banks (ping-pong); write bank pointer wrBank, read bank pointer rdBank, 4-bit counters wrCnt and rdCnt, per-bank full flags.
REQ-013 inReady = ~full[wrBank], combinational.
REQ-014 Input accept on inValid & inReady: bank[wrBank][wrCnt] <= dIn; wrCnt increments with wrap 15->0; at wrCnt==15, full[wrBank] set and wrBank toggles.
REQ-015 outValid = full[rdBank]; dOut = bank[rdBank][src(rdCnt)] when outValid, else 8'h00.
REQ-016 src(k), row = k[1:0], col = k[3:2]: INV=0 -> row + 4*((col+row) mod 4); INV=1 -> row + 4*((col-row) mod 4).
REQ-017 Output accept on outValid & outReady: rdCnt increments with wrap; at rdCnt==15, full[rdBank] clears and rdBank toggles.
REQ-018 colFirst = outValid & (rdCnt[1:0]==0); outLast = outValid & (rdCnt==15).
REQ-019 Latency: 16th input byte accepted at edge N -> outValid high after edge N, when the other bank is empty.
REQ-020 Throughput: with inValid and outReady held high, sustained 1 byte/cycle in and out, no bubbles.
REQ-021 Full: both banks full -> inReady low; dIn ignored; no state change on the write side.
REQ-022 Simultaneous fill of one bank and drain completion of the other in the same cycle: both flag updates take effect.
REQ-023 outReady low holds dOut, colFirst, outLast and rdCnt stable.
REQ-024 inValid low mid-block: wrCnt holds; the partial block resumes on the next valid byte.

Reset
REQ-025 On rst: wrCnt=0, rdCnt=0, wrBank=0, rdBank=0, both full flags 0 -> outValid=0, dOut=8'h00, colFirst=0, outLast=0, inReady=1.
REQ-026 Bank data is not reset.
REQ-027 Reset mid-block discards all partial and complete blocks.
REQ-028 The first byte accepted after reset deasserts is index 0.

Structure
REQ-029 The shared AES package holds the block-size constant (16), the byte type, and the src() index function parameterised by INV.
REQ-030 Single module, no sub-module; the index mapping comes only from the package function.

Verification
REQ-031 INV=0, input bytes 00..0f back-to-back -> dOut 00 05 0a 0f 04 09 0e 03 08 0d 02 07 0c 01 06 0b; colFirst on bytes 0, 4, 8, 12; outLast on byte 15.
REQ-032 INV=0, FIPS-197 App. B round-1 SubBytes state d4 27 11 ae e0 bf 98 f1 b8 b4 5d e5 1e 41 52 30 -> dOut d4 bf 5d 30 e0 b4 52 ae b8 41 11 f1 1e 27 98 e5.
REQ-033 INV=1, input 00..0f -> dOut 00 0d 0a 07 04 01 0e 0b 08 05 02 0f 0c 09 06 03.
REQ-034 outReady=0, three blocks offered -> 32 bytes accepted, then inReady low; releasing outReady drains blocks in order with no byte loss or duplication.
REQ-035 Continuous streaming of 4 blocks with inValid=outReady=1 -> 64 outputs in 64 consecutive cycles, the first one cycle after the 16th input.
REQ-036 rst pulsed after input byte 7 of a block -> all outputs at reset values; the next 16 bytes form a fresh block with correct output.
